// File: rtl/mask_pool_pkg.sv
// Shared types and elaboration-time width helpers for the mask pooling stream.
package mask_pool_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Counter width that never collapses to zero bits.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Tile count width: POOL*POOL must be representable.
  function automatic int count_w(input int pool);
    return $clog2(pool * pool + 1);
  endfunction

  function automatic int tiles_of(input int pixels, input int pool);
    return pixels / pool;
  endfunction

endpackage

// File: rtl/mask_pool_raster_ctr.sv
// Raster position tracker split into in-tile offset and tile index per axis,
// so tile column and tile boundaries fall out without any division.
module mask_pool_raster_ctr
  import mask_pool_pkg::*;
#(
  parameter int POOL    = 10,
  parameter int TILES_X = 30,
  parameter int TILES_Y = 20,
  localparam int PW = clog2w(POOL),
  localparam int XW = clog2w(TILES_X),
  localparam int YW = clog2w(TILES_Y)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          start,
  output logic [XW-1:0] tile_col,
  output logic          last_in_tile,
  output logic          tile_row_end,
  output logic          last_pixel
);

  localparam logic [PW-1:0] P_LAST = PW'(POOL - 1);
  localparam logic [XW-1:0] X_LAST = XW'(TILES_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(TILES_Y - 1);

  logic [PW-1:0] in_col_reg, in_row_reg, in_col, in_row;
  logic [XW-1:0] t_col_reg;
  logic [YW-1:0] t_row_reg, t_row;
  logic          row_end;

  // A start beat is pixel (0,0) regardless of where the counters stood.
  assign in_col   = start ? '0 : in_col_reg;
  assign in_row   = start ? '0 : in_row_reg;
  assign tile_col = start ? '0 : t_col_reg;
  assign t_row    = start ? '0 : t_row_reg;

  assign last_in_tile = (in_col == P_LAST);
  assign row_end      = last_in_tile && (tile_col == X_LAST);
  assign tile_row_end = (in_row == P_LAST);
  assign last_pixel   = row_end && tile_row_end && (t_row == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col_reg <= '0;
      in_row_reg <= '0;
      t_col_reg  <= '0;
      t_row_reg  <= '0;
    end else if (step) begin
      in_col_reg <= last_in_tile ? '0 : in_col + PW'(1);
      if (!last_in_tile)
        t_col_reg <= tile_col;
      else
        t_col_reg <= (tile_col == X_LAST) ? '0 : tile_col + XW'(1);
      if (row_end) begin
        in_row_reg <= tile_row_end ? '0 : in_row + PW'(1);
        if (!tile_row_end)
          t_row_reg <= t_row;
        else
          t_row_reg <= (t_row == Y_LAST) ? '0 : t_row + YW'(1);
      end else begin
        in_row_reg <= in_row;
        t_row_reg  <= t_row;
      end
    end
  end

endmodule

// File: rtl/mask_pool_stream.sv
// Pools a raster binary mask into POOLxPOOL tile counts with a thresholded bit,
// behind a single-entry output register on a valid/ready stream.
module mask_pool_stream
  import mask_pool_pkg::*;
#(
  parameter int IMG_W  = 300,
  parameter int IMG_H  = 200,
  parameter int POOL   = 10,
  parameter int THRESH = 50,
  localparam int CW = count_w(POOL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_pixel,
  input  logic          s_sof,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_count,
  output logic          m_bit,
  output logic          m_last,
  output logic          frame_done,
  output logic          err_sof
);

  localparam int TX = tiles_of(IMG_W, POOL);
  localparam int TY = tiles_of(IMG_H, POOL);
  localparam int XW = clog2w(TX);
  localparam logic [CW-1:0] TH = CW'(THRESH);

  if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_bad_geometry
    $error("mask_pool_stream: IMG_W and IMG_H must be multiples of POOL");
  end

  state_e        state_reg, state_next;
  logic          accept, step, start, err_set, emit;
  logic [XW-1:0] tile_col;
  logic          last_in_tile, tile_row_end, last_pixel;
  logic [CW-1:0] acc_reg [TX];
  logic [CW-1:0] acc_sel, tile_sum;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  mask_pool_raster_ctr #(
    .POOL    (POOL),
    .TILES_X (TX),
    .TILES_Y (TY)
  ) u_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         (step),
    .start        (start),
    .tile_col     (tile_col),
    .last_in_tile (last_in_tile),
    .tile_row_end (tile_row_end),
    .last_pixel   (last_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start)               state_next = ACTIVE;
    if (step && last_pixel)  state_next = IDLE;
  end

  // In IDLE only a start-of-frame beat counts; everything else is dropped.
  always_comb begin
    start   = accept && s_sof;
    step    = accept && (s_sof || state_reg == ACTIVE);
    err_set = start && (state_reg == ACTIVE);
  end

  assign emit     = step && last_in_tile && tile_row_end;
  assign acc_sel  = start ? '0 : acc_reg[tile_col];
  assign tile_sum = acc_sel + CW'(s_pixel);

  // A start beat wipes partial tiles of an aborted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TX; i++) acc_reg[i] <= '0;
    end else if (step) begin
      for (int i = 0; i < TX; i++) begin
        if (tile_col == XW'(i)) acc_reg[i] <= emit ? '0 : tile_sum;
        else if (start)         acc_reg[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_count    <= '0;
      m_bit      <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      frame_done <= m_valid && m_ready && m_last;
      if (emit) begin
        m_valid <= 1'b1;
        m_count <= tile_sum;
        m_bit   <= (tile_sum >= TH);
        m_last  <= last_pixel;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (err_set) err_sof <= 1'b1;
    end
  end

endmodule
